// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-side definitions: widths, the fetch FSM state encoding,
// the buffered entry layout and the default reset vector.
package rv32_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DROP} fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// Small {pc, instr} FIFO between fetch and decode; flush wins over push/pop.
module instr_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_instr,
  input  logic            pop,
  input  logic            flush,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_instr,
  output logic [CW-1:0]   count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;
endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch unit: issues word fetches, buffers
// responses for decode, and handles redirects by flushing and dropping stale data.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_e  state;
  logic [31:0]   fetch_pc, req_pc;
  logic [CW-1:0] count;
  logic          req_hs, push, pop;

  // Gated by reset so the request line is quiet while reset is held.
  assign imem_req_valid = reset && (state == ST_FETCH) &&
                          (count < CW'(BUF_DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign instr_valid    = (count != '0);
  assign pop            = instr_valid & instr_ready;
  assign push           = (state == ST_WAIT) & imem_resp_valid & ~redirect_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_FETCH;
      fetch_pc <= {RESET_PC[31:2], 2'b00};
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      // An in-flight fetch is now stale; wait it out unless it lands this cycle.
      case (state)
        ST_WAIT, ST_DROP: state <= imem_resp_valid ? ST_FETCH : ST_DROP;
        default:          state <= ST_FETCH;
      endcase
    end else begin
      case (state)
        ST_FETCH: if (req_hs) begin
          req_pc   <= fetch_pc;
          fetch_pc <= fetch_pc + 32'd4;
          state    <= ST_WAIT;
        end
        ST_WAIT:  if (imem_resp_valid) state <= ST_FETCH;
        ST_DROP:  if (imem_resp_valid) state <= ST_FETCH;
        default:  state <= ST_FETCH;
      endcase
    end
  end

  instr_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_pc    (req_pc),
    .push_instr (imem_resp_data),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (count)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a
// queue-based reference of the fetch rules and a simple memory responder.
module tb_instr_fetch;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        redirect_valid, instr_valid, instr_ready;
  logic [31:0] redirect_pc, instr, instr_pc;

  instr_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  int n_chk = 0, n_pass = 0, cyc = 0;

  // reference state: 0 = nothing outstanding, 1 = outstanding kept, 2 = outstanding dropped
  ent_t        m_buf[$];
  logic [31:0] m_pc, m_req;
  int          m_out;
  // memory responder
  logic        mem_busy;
  int          mem_wait;
  logic [31:0] mem_data, rdata;
  // stimulus knobs
  logic        d_ready, d_iready, d_redir, d_spur;
  logic [31:0] d_rpc;
  int          d_lat;
  // observation logs
  logic [31:0] acc_log[$], pop_log[$];
  int          pop_cyc[$];
  int          n_req;
  logic        last_rv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    m_buf.delete(); m_pc = RPC; m_req = '0; m_out = 0; mem_busy = 1'b0; mem_wait = 0;
    acc_log.delete(); pop_log.delete(); pop_cyc.delete(); n_req = 0;
  endtask

  task automatic tick();
    logic exp_rv, acc, pop, rsp, memr;
    ent_t e;
    @(negedge clk);
    memr  = mem_busy && (mem_wait == 0);
    rsp   = mem_busy ? memr : d_spur;
    rdata = memr ? mem_data : $urandom;
    imem_resp_valid = rsp; imem_resp_data = rdata;
    imem_req_ready = d_ready; instr_ready = d_iready;
    redirect_valid = d_redir; redirect_pc = d_rpc;
    #1;
    exp_rv = (m_out == 0) && (m_buf.size() < DEPTH) && !d_redir;
    chk("req_valid", imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", imem_req_addr, m_pc);
    chk("instr_valid", instr_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) begin
      chk("instr_pc", instr_pc, m_buf[0].pc);
      chk("instr", instr, m_buf[0].data);
    end
    acc = exp_rv && d_ready;
    pop = (m_buf.size() != 0) && d_iready;
    last_rv = exp_rv;
    if (exp_rv) n_req++;
    if (acc) acc_log.push_back(m_pc);
    if (pop) begin pop_log.push_back(m_buf[0].pc); pop_cyc.push_back(cyc); end
    @(posedge clk);
    if (d_redir) begin
      m_pc = {d_rpc[31:2], 2'b00};
      m_buf.delete();
      if (m_out != 0) m_out = rsp ? 0 : 2;
    end else begin
      if (pop) e = m_buf.pop_front();
      if (rsp && m_out == 1) m_buf.push_back('{pc: m_req, data: rdata});
      if (rsp && m_out != 0) m_out = 0;
      if (acc) begin m_req = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
    end
    if (mem_busy) begin
      if (mem_wait == 0) mem_busy = 1'b0;
      else mem_wait--;
    end
    if (acc) begin mem_busy = 1'b1; mem_wait = d_lat; mem_data = $urandom; end
    cyc++;
  endtask

  task automatic drive_idle();
    imem_req_ready = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; imem_resp_valid = 1'b0; imem_resp_data = '0;
  endtask

  task automatic do_reset(input logic check);
    @(negedge clk);
    reset = 1'b0; drive_idle(); model_clear();
    #1;
    if (check) begin
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_instr_pc", instr_pc, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    d_ready = 1'b1; d_iready = 1'b1; d_redir = 1'b0; d_spur = 1'b0; d_rpc = '0; d_lat = 0;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    drive_idle();
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_instr_valid", instr_valid, 1'b0);
    chk("mid_rst_req_valid", imem_req_valid, 1'b0);
    model_clear();
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  initial begin
    int k;
    reset = 1'b0; drive_idle(); model_clear();
    d_ready = 1'b0; d_iready = 1'b0; d_redir = 1'b0; d_spur = 1'b0; d_rpc = '0; d_lat = 0;

    // reset state, then back-to-back fetches with 1-cycle memory
    do_reset(1'b1);
    for (int i = 0; i < 8; i++) tick();
    chk("seq_pc0", qget(pop_log, 0), 32'h100);
    chk("seq_pc1", qget(pop_log, 1), 32'h104);
    chk("seq_pc2", qget(pop_log, 2), 32'h108);
    chk("seq_first_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - 0 : -1, 2);
    chk("seq_gap", (pop_cyc.size() > 1) ? pop_cyc[1] - pop_cyc[0] : -1, 2);

    // decoder stalled: buffer fills, fetch stops, then drains in order
    do_reset(1'b0);
    d_iready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_req_count", n_req, DEPTH);
    chk("stall_req_off", last_rv, 1'b0);
    d_iready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    for (int i = 0; i < DEPTH; i++) chk("drain_order", qget(pop_log, i), RPC + 32'(4 * i));

    // redirect while waiting: stale response dropped, fetch resumes at aligned target
    do_reset(1'b0);
    d_lat = 2;
    tick();
    d_redir = 1'b1; d_rpc = 32'h203; d_lat = 0;
    tick();
    d_redir = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("drop_req1", qget(acc_log, 1), 32'h200);
    chk("drop_pop0", qget(pop_log, 0), 32'h200);

    // redirect coinciding with the response
    do_reset(1'b0);
    tick();
    d_redir = 1'b1; d_rpc = 32'h340;
    tick();
    d_redir = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("same_req1", qget(acc_log, 1), 32'h340);
    chk("same_pop0", qget(pop_log, 0), 32'h340);

    // address wrap at the top of the address space
    do_reset(1'b0);
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFFF;
    tick();
    d_redir = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("wrap_req0", qget(acc_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", qget(acc_log, 1), 32'h0);
    chk("wrap_pop1", qget(pop_log, 1), 32'h0);

    // reset while waiting with two entries buffered, late response ignored
    do_reset(1'b0);
    d_iready = 1'b0; d_lat = 2;
    k = 0;
    while (!(m_buf.size() == 2 && m_out == 1) && k < 30) begin tick(); k++; end
    chk("wait2_reached", (m_buf.size() == 2 && m_out == 1), 1'b1);
    reset_mid();
    d_spur = 1'b1; d_lat = 0; d_iready = 1'b1;
    tick();
    d_spur = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("post_rst_req0", qget(acc_log, 0), RPC);
    chk("post_rst_pop0", qget(pop_log, 0), RPC);

    // random traffic
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) reset_mid();
      d_ready  = ($urandom_range(0, 9) < 7);
      d_iready = ($urandom_range(0, 9) < 6);
      d_redir  = !d_redir && ($urandom_range(0, 19) == 0);
      d_rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      d_lat    = $urandom_range(0, 2);
      d_spur   = ($urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter BUF_DEPTH, default 2: instruction buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  byte address of the word fetch.
REQ-008 imem_resp_valid  input  1  response data valid; earliest one cycle after request acceptance.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  control-flow change from execute; single-cycle pulse.
REQ-011 redirect_pc  input  32  new fetch address; bits [1:0] SHALL be ignored and treated as 0.
REQ-012 instr_valid  output  1  buffer head holds an instruction for the decoder.
REQ-013 instr_ready  input  1  decoder consumes the head this cycle.
REQ-014 instr  output  32  instruction word at the buffer head.
REQ-015 instr_pc  output  32  address of instr.

Function
REQ-016 FSM states: FETCH (none outstanding), WAIT (one outstanding, kept), DROP (one outstanding, to discard); at most one request SHALL be outstanding.
REQ-017 imem_req_valid SHALL be 1 only in FETCH with buffer count < BUF_DEPTH and redirect_valid=0; imem_req_addr = fetch_pc.
REQ-018 On request handshake: req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0), state -> WAIT.
REQ-019 In WAIT with imem_resp_valid=1: push {req_pc, imem_resp_data} into the buffer; state -> FETCH; imem_resp_valid in FETCH SHALL be ignored.
REQ-020 instr_valid = (count != 0); instr/instr_pc = head entry; pop on instr_valid & instr_ready.
REQ-021 Simultaneous push and pop: count unchanged, order preserved (FIFO); push into a full buffer cannot occur by REQ-017.
REQ-022 Latency: with imem_req_ready=1 and response one cycle later, instr_valid SHALL rise two cycles after the request cycle; sustained throughput is one instruction per two cycles.
REQ-023 Redirect (priority over all other events): fetch_pc <= {redirect_pc[31:2],2'b00}; buffer flushed (count <= 0) at that edge; a pop handshake in the redirect cycle still counts as consumed.
REQ-024 Redirect in WAIT without response: state -> DROP; redirect in WAIT with imem_resp_valid same cycle: response discarded, state -> FETCH.
REQ-025 Redirect in FETCH: no request issued that cycle (REQ-017); state stays FETCH.
REQ-026 DROP: imem_resp_valid discards the data, state -> FETCH; redirect in DROP updates fetch_pc, stays DROP.
REQ-027 A pending un-accepted request MAY change address only after a redirect; otherwise imem_req_addr SHALL be stable while imem_req_valid=1 and imem_req_ready=0.

Reset
REQ-028 While reset=0: state FETCH, fetch_pc = RESET_PC, count = 0, imem_req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-029 First cycle after reset release SHALL present imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-030 Reset asserted mid-operation SHALL abandon outstanding requests; any response arriving after release in FETCH is ignored.

Structure
REQ-031 Shared package rv32_pkg SHALL hold XLEN=32, ILEN=32, fetch FSM state enum, and default RESET_PC.
REQ-032 Buffer SHALL be sub-module instr_fifo (BUF_DEPTH x {pc, instr}, push/pop/flush, count), instantiated once.

Verification
REQ-033 Reset release, RESET_PC=0x100, ready=1, 1-cycle response -> instr_pc sequence 0x100, 0x104, 0x108 with matching data, one per two cycles.
REQ-034 instr_ready=0 for 10 cycles -> exactly BUF_DEPTH requests issued, then imem_req_valid=0; release -> entries drain in order.
REQ-035 Redirect to 0x203 while WAIT -> DROP; stale response discarded; next request addr 0x200; first instr_pc 0x200.
REQ-036 Redirect same cycle as response in WAIT -> response dropped, next request addr = redirect target.
REQ-037 fetch_pc 0xFFFF_FFFC -> following request addr 0x0000_0000.
REQ-038 reset asserted during WAIT with 2 buffered entries -> instr_valid=0 immediately; after release first request addr = RESET_PC.
